// File: rtl/fetch_unit.sv
// Instruction fetch unit: assembles one- and two-word instructions into the F/D stage.
// Optional macro RESET_VECTOR_EN: boot by loading the start PC from memory words 0 and 1.
module fetch_unit #(
  parameter int unsigned            PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [15:0]         fd_ir,
  output logic [15:0]         fd_imm,
  output logic [PC_WIDTH-1:0] fd_pc,
  output logic                fd_valid
);

`ifdef RESET_VECTOR_EN
  typedef enum logic [1:0] {FETCH, IMM, BOOT_LO, BOOT_HI} state_t;
  localparam state_t RESET_STATE = BOOT_LO;
  localparam int unsigned EXT_W = (PC_WIDTH > 32) ? PC_WIDTH : 32;
  logic [EXT_W-1:0] boot_pc;
`else
  typedef enum logic {FETCH, IMM} state_t;
  localparam state_t RESET_STATE = FETCH;
`endif

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         hold_ir_q, hold_ir_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [15:0]         fd_ir_q, fd_ir_d;
  logic [15:0]         fd_imm_q, fd_imm_d;
  logic [PC_WIDTH-1:0] fd_pc_q, fd_pc_d;
  logic                fd_valid_q, fd_valid_d;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Memory address: PC while fetching, fixed vector words while booting.
  always_comb begin
    imem_addr = pc_q;
`ifdef RESET_VECTOR_EN
    if (state_q == BOOT_LO) imem_addr = '0;
    if (state_q == BOOT_HI) imem_addr = PC_WIDTH'(1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      pc_q       <= RESET_PC;
      hold_ir_q  <= '0;
      hold_pc_q  <= '0;
      fd_ir_q    <= '0;
      fd_imm_q   <= '0;
      fd_pc_q    <= '0;
      fd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_ir_q  <= hold_ir_d;
      hold_pc_q  <= hold_pc_d;
      fd_ir_q    <= fd_ir_d;
      fd_imm_q   <= fd_imm_d;
      fd_pc_q    <= fd_pc_d;
      fd_valid_q <= fd_valid_d;
    end
  end

  // Next state: redirect beats flush beats stall beats normal advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_ir_d  = hold_ir_q;
    hold_pc_d  = hold_pc_q;
    fd_ir_d    = fd_ir_q;
    fd_imm_d   = fd_imm_q;
    fd_pc_d    = fd_pc_q;
    fd_valid_d = fd_valid_q;
`ifdef RESET_VECTOR_EN
    boot_pc    = EXT_W'(pc_q);
`endif

    case (state_q)
`ifdef RESET_VECTOR_EN
      BOOT_LO: begin
        boot_pc[15:0] = imem_rdata;
        pc_d          = PC_WIDTH'(boot_pc);
        fd_valid_d    = 1'b0;
        state_d       = BOOT_HI;
      end
      BOOT_HI: begin
        boot_pc[31:16] = imem_rdata;
        pc_d           = PC_WIDTH'(boot_pc);
        fd_valid_d     = 1'b0;
        state_d        = FETCH;
      end
`endif
      IMM: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          state_d    = FETCH;
          fd_valid_d = 1'b0;
        end else if (flush) begin
          pc_d       = hold_pc_q;
          state_d    = FETCH;
          fd_valid_d = 1'b0;
        end else if (!stall) begin
          fd_ir_d    = hold_ir_q;
          fd_imm_d   = imem_rdata;
          fd_pc_d    = hold_pc_q;
          fd_valid_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = FETCH;
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          fd_valid_d = 1'b0;
        end else if (flush) begin
          fd_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d = pc_inc;
          if (imem_rdata[15]) begin
            hold_ir_d  = imem_rdata;
            hold_pc_d  = pc_q;
            fd_valid_d = 1'b0;
            state_d    = IMM;
          end else begin
            fd_ir_d    = imem_rdata;
            fd_imm_d   = '0;
            fd_pc_d    = pc_q;
            fd_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign fd_ir    = fd_ir_q;
  assign fd_imm   = fd_imm_q;
  assign fd_pc    = fd_pc_q;
  assign fd_valid = fd_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit in its default build (no boot vector).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] fd_ir, fd_imm;
  logic [31:0] fd_pc;
  logic        fd_valid;

  logic [15:0] mem [0:255];
  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        st;
    logic        fl;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [15:0] eir;
    logic [15:0] eimm;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fd_ir          (fd_ir),
    .fd_imm         (fd_imm),
    .fd_pc          (fd_pc),
    .fd_valid       (fd_valid)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic add(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [15:0] eir, input logic [15:0] eimm,
                     input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.eir = eir; v.eimm = eimm; v.epc = epc; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [15:0] eir,
                           input logic [15:0] eimm, input logic [31:0] epc, input logic [31:0] eaddr);
    check({tag, ".fd_valid"}, 32'(fd_valid), 32'(ev));
    check({tag, ".fd_ir"}, 32'(fd_ir), 32'(eir));
    check({tag, ".fd_imm"}, 32'(fd_imm), 32'(eimm));
    check({tag, ".fd_pc"}, fd_pc, epc);
    check({tag, ".imem_addr"}, imem_addr, eaddr);
  endtask

  task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h1234; mem[1]  = 16'h0042; mem[2]  = 16'h0003; mem[3]  = 16'h0004;
    mem[4]  = 16'h8A01; mem[5]  = 16'hBEEF; mem[6]  = 16'h0006; mem[7]  = 16'h0777;
    mem[8]  = 16'h0008; mem[9]  = 16'h0009; mem[10] = 16'h8B02; mem[11] = 16'hCAFE;
    mem[12] = 16'h000C; mem[64] = 16'h1040; mem[65] = 16'h1041; mem[255] = 16'h0055;

    // st fl rv rpc | valid ir imm fd_pc next_addr
    add(0,0,0,0,     1,16'h1234,16'h0000,32'd0, 32'd1);
    add(0,0,0,0,     1,16'h0042,16'h0000,32'd1, 32'd2);
    add(0,0,0,0,     1,16'h0003,16'h0000,32'd2, 32'd3);
    add(0,0,0,0,     1,16'h0004,16'h0000,32'd3, 32'd4);
    add(0,0,0,0,     0,16'h0004,16'h0000,32'd3, 32'd5);
    add(0,0,0,0,     1,16'h8A01,16'hBEEF,32'd4, 32'd6);
    add(0,0,0,0,     1,16'h0006,16'h0000,32'd6, 32'd7);
    add(1,0,0,0,     1,16'h0006,16'h0000,32'd6, 32'd7);
    add(1,0,0,0,     1,16'h0006,16'h0000,32'd6, 32'd7);
    add(1,0,0,0,     1,16'h0006,16'h0000,32'd6, 32'd7);
    add(0,0,0,0,     1,16'h0777,16'h0000,32'd7, 32'd8);
    add(0,1,0,0,     0,16'h0777,16'h0000,32'd7, 32'd8);
    add(0,0,0,0,     1,16'h0008,16'h0000,32'd8, 32'd9);
    add(0,0,0,0,     1,16'h0009,16'h0000,32'd9, 32'd10);
    add(0,0,0,0,     0,16'h0009,16'h0000,32'd9, 32'd11);
    add(1,0,1,32'h40,0,16'h0009,16'h0000,32'd9, 32'h40);
    add(0,0,0,0,     1,16'h1040,16'h0000,32'h40,32'h41);
    add(0,0,1,32'd10,0,16'h1040,16'h0000,32'h40,32'd10);
    add(0,0,0,0,     0,16'h1040,16'h0000,32'h40,32'd11);
    add(0,1,0,0,     0,16'h1040,16'h0000,32'h40,32'd10);
    add(0,0,0,0,     0,16'h1040,16'h0000,32'h40,32'd11);
    add(0,0,0,0,     1,16'h8B02,16'hCAFE,32'd10,32'd12);
    add(1,1,0,0,     0,16'h8B02,16'hCAFE,32'd10,32'd12);
    add(0,1,1,32'h41,0,16'h8B02,16'hCAFE,32'd10,32'h41);
    add(0,0,0,0,     1,16'h1041,16'h0000,32'h41,32'h42);

    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = '0;
    reset = 1'b1;
    #1;
    check_all("reset", 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].rpc);
      check_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].eir, vecs[i].eimm,
                vecs[i].epc, vecs[i].eaddr);
      @(negedge clk);
    end

    // PC wrap from all-ones to zero.
    step(0, 0, 1, 32'hFFFF_FFFF);
    check("wrap.redirect_addr", imem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    step(0, 0, 0, 0);
    check_all("wrap", 1'b1, 16'h0055, 16'h0000, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);

    // Reset asserted while a two-word instruction is half assembled.
    step(0, 0, 1, 32'd4);
    @(negedge clk);
    step(0, 0, 0, 0);
    check("midimm.valid_before", 32'(fd_valid), 32'd0);
    check("midimm.addr_before", imem_addr, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check_all("midimm.reset", 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0);
    check_all("midimm.after", 1'b1, 16'h1234, 16'h0000, 32'h0, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
